core_scheduler: RTL
===================

# core_scheduler

Per-core control FSM that sequences the pipeline stages seen by every thread's register file, ALU and LSU. It walks `core_state` through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE, stalls on the fetcher and LSUs, and owns the core's program counter. One instance sits in each core, broadcasting `core_state` and `current_pc` to all thread lanes.

## Interface
Parameters:
- THREADS_PER_BLOCK, 4, number of thread lanes in the core
- PROGRAM_ADDR_BITS, 8, program counter width

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch block; level, held by dispatcher until `done`
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads in this block; lanes ≥ count are disabled
- decoded_mem_read_enable  in  1  current instruction is LDR
- decoded_mem_write_enable  in  1  current instruction is STR
- decoded_ret  in  1  current instruction is RET
- fetcher_state  in  3  000 IDLE, 001 FETCHING, 010 FETCHED
- lsu_state  in  2*THREADS_PER_BLOCK  per lane; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
- next_pc  in  PROGRAM_ADDR_BITS*THREADS_PER_BLOCK  per-lane next PC from branch units
- current_pc  out  PROGRAM_ADDR_BITS  PC of instruction being executed
- core_state  out  3  000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
- done  out  1  block finished (RET retired)
- divergence_error  out  1  sticky; active lanes disagreed on next PC

## Operation
- Reset values: core_state IDLE, current_pc 0, done 0, divergence_error 0, latched count 0.
- IDLE: on `start`=1, latch `thread_count`, clear divergence_error, current_pc=0, → FETCH.
- FETCH: hold until fetcher_state==FETCHED, → DECODE.
- DECODE, REQUEST, EXECUTE: one cycle each, → next stage.
- WAIT: if neither mem enable set → EXECUTE next cycle. Otherwise hold until every active lane (index < latched count) reports lsu_state==DONE; disabled lanes ignored. Latched count 0 → WAIT exits after one cycle.
- UPDATE: if decoded_ret → DONE, done=1. Else current_pc ← next_pc of lane 0 (lowest active), → FETCH.
- Divergence: in UPDATE (non-RET), if any active lane's next_pc ≠ lane 0's, set divergence_error=1 (sticky until next launch); execution continues with lane 0's PC.
- DONE: done held 1 while `start`=1. When `start` drops → IDLE, done=0; current_pc holds until next launch.
- `start` toggles outside IDLE/DONE are ignored; thread_count changes after latch are ignored.
- PC arithmetic is owned by lanes; next_pc wraps naturally modulo 2^PROGRAM_ADDR_BITS, no special case.
- Illegal core_state encodings impossible; default branch → IDLE.

## Timing
- All outputs registered; core_state changes on the rising clock edge following the qualifying condition.
- reset asserted (low) at any time forces reset values immediately, regardless of clock; pipeline abandoned mid-instruction.
- Non-memory instruction with fetcher FETCHED on first FETCH cycle: 6 cycles FETCH→next FETCH (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- Fetch stall of N extra cycles adds N; memory instruction adds cycles until last active lane reaches DONE (WAIT minimum 1 cycle).
- current_pc updates on the UPDATE→FETCH edge; register file sees REQUEST (011) and UPDATE (110) exactly one cycle each per instruction.
- done rises on the UPDATE→DONE edge; falls one cycle after `start` low is sampled in DONE.

## Test plan
- Reset low mid-WAIT → core_state=000, current_pc=0, done=0 asynchronously, before next edge.
- start=1, count=4, fetcher FETCHED immediately, ALU ops, all next_pc=pc+1 → states 001,010,011,100,101,110 repeat every 6 cycles, current_pc 0,1,2.
- LDR with lanes 0–2 DONE at cycle 3, lane 3 DONE at cycle 7 → WAIT held until lane 3 DONE, then EXECUTE.
- count=2, LDR, lanes 2–3 stuck IDLE, lanes 0–1 DONE → WAIT exits; lanes 2–3 next_pc=0xFF ignored, no divergence_error.
- next_pc = {5,5,9,5}, count=4 → current_pc=5, divergence_error=1 held until next start.
- RET at pc 3 → done=1 stays with start high; drop start → IDLE, done=0; relaunch restarts at pc 0.

Source files
------------

// File: rtl/core_scheduler.sv
// Per-core pipeline sequencer: steps core_state through the instruction stages,
// stalls on the fetcher and LSUs, and owns the block's program counter.
//
// state   | meaning
// IDLE    | waiting for a block launch
// FETCH   | instruction fetch in progress, held until the fetcher reports FETCHED
// DECODE  | decoder latches the fetched instruction
// REQUEST | register files read operands, LSUs issue memory requests
// WAIT    | held until every active lane's LSU is DONE (memory ops only)
// EXECUTE | ALUs and branch units compute
// UPDATE  | register write-back, PC advance or retire on RET
// DONE    | block finished, held until the dispatcher drops start
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PROGRAM_ADDR_BITS = 8
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]             thread_count,
  input  logic                                           decoded_mem_read_enable,
  input  logic                                           decoded_mem_write_enable,
  input  logic                                           decoded_ret,
  input  logic [2:0]                                     fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]                 lsu_state,
  input  logic [PROGRAM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [PROGRAM_ADDR_BITS-1:0]                   current_pc,
  output logic [2:0]                                     core_state,
  output logic                                           done,
  output logic                                           divergence_error
);

  localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int PA = PROGRAM_ADDR_BITS;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_DONE        = 2'b11;

  logic [CW-1:0] active_count;
  logic          lanes_done;
  logic          lanes_diverge;
  logic [PA-1:0] lane0_pc;
  logic          mem_op;

  assign mem_op = decoded_mem_read_enable | decoded_mem_write_enable;

  // Lanes at or above the latched count are disabled and never stall or diverge.
  always_comb begin
    lanes_done    = 1'b1;
    lanes_diverge = 1'b0;
    lane0_pc      = next_pc[PA-1:0];
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (CW'(i) < active_count) begin
        if (lsu_state[2*i +: 2] != LSU_DONE) lanes_done = 1'b0;
        if (next_pc[PA*i +: PA] != lane0_pc) lanes_diverge = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_state       <= S_IDLE;
      current_pc       <= '0;
      done             <= 1'b0;
      divergence_error <= 1'b0;
      active_count     <= '0;
    end else begin
      case (core_state)
        S_IDLE: begin
          if (start) begin
            active_count     <= thread_count;
            divergence_error <= 1'b0;
            current_pc       <= '0;
            core_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetcher_state == FETCHER_FETCHED) core_state <= S_DECODE;
        end
        S_DECODE:  core_state <= S_REQUEST;
        S_REQUEST: core_state <= S_WAIT;
        S_WAIT: begin
          if (!mem_op || lanes_done) core_state <= S_EXECUTE;
        end
        S_EXECUTE: core_state <= S_UPDATE;
        S_UPDATE: begin
          if (decoded_ret) begin
            done       <= 1'b1;
            core_state <= S_DONE;
          end else begin
            // Divergent lanes are flagged but the block follows lane 0.
            current_pc <= lane0_pc;
            if (lanes_diverge) divergence_error <= 1'b1;
            core_state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!start) begin
            done       <= 1'b0;
            core_state <= S_IDLE;
          end
        end
        default: core_state <= S_IDLE;
      endcase
    end
  end

endmodule
